stream_deserialize: RTL
=======================

Name: stream_deserialize

Overview:
- Receive end of the gated serial sample chain.
- The chain loads all stages on a snapshot strobe, then shifts words out one per clock with a gate.
- This block rebuilds each gated burst into an n_chan-word frame, double-buffered, and publishes it atomically.
- A registered read port serves host or readout logic. Short and long bursts are flagged and never published.

Parameters:
- dwi, 28, word width; equals the chain width.
- n_chan, 8, words per frame (number of chain stages); must be at least 2.
- aw, 3, read address width; 2**aw >= n_chan.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- stream_in  in  dwi  signed word from the end of the chain
- gate_in  in  1  high when stream_in carries a valid word
- strobe_in  in  1  snapshot strobe of the chain; the next gated word is word 0 of a new frame
- frame_valid  out  1  one-cycle pulse when a new frame is published
- frame_count  out  16  published frames, wraps modulo 2**16
- rd_addr  in  aw  word index into the published frame
- rd_data  out  dwi  published word, registered
- err_short  out  1  sticky: burst ended or restarted before n_chan words
- err_long  out  1  sticky: gated words arrived after a complete frame
- err_clear  in  1  clears both sticky flags

Behaviour:
- Reset values: all outputs 0; state IDLE; word counter cnt=0; bank select 0. Bank contents are not cleared.
- Word order: the first gated word after strobe_in (or from IDLE) goes to index 0, then 1, 2, and so on.
- States:
  - IDLE: gate_in=1 writes stream_in to cap[0], sets cnt=1, goes to CAPTURE. gate_in=0 stays in IDLE.
  - CAPTURE, gate_in=1: writes cap[cnt], cnt++.
    - If the word written has index n_chan-1: toggle bank select, frame_count++, go to DONE.
    - frame_valid is high the cycle after the last word is written.
  - CAPTURE, gate_in=0: set err_short, discard the partial frame, cnt=0, go to IDLE.
  - DONE, gate_in=1 without strobe_in: set err_long, ignore the word, stay in DONE.
  - DONE, gate_in=0: go to IDLE.
- strobe_in (any state), same cycle:
  - The word present this cycle is processed by the rules above first.
  - Then cnt=0 and state=IDLE, so back-to-back frames with a continuously high gate are accepted.
  - If this happens in CAPTURE and the current word does not complete the frame, set err_short.
  - A strobe on the exact completing cycle is legal: publish normally, no error.
- Publishing:
  - The capture bank becomes the readable bank on the toggle.
  - A partial frame never reaches the readable bank.
  - The readable bank is stable until the next frame_valid.
- Read port:
  - rd_data <= bank[readable][rd_addr], one-cycle latency, every cycle.
  - rd_addr >= n_chan returns 0.
  - A read in the same cycle as the toggle returns the old frame; the next cycle returns the new one.
- Sticky errors:
  - Set wins over err_clear in the same cycle.
  - err_clear alone clears both flags next cycle.
- Mid-operation rst: abandons capture, no frame_valid, no error flags; the next frame starts clean.
- Arithmetic: frame_count wraps 0xFFFF->0. cnt is $clog2(n_chan+1) bits and never exceeds n_chan.

Decomposition:
- No shared package; state encodings (IDLE, CAPTURE, DONE) are localparams in the module.
- One natural sub-module: deser_bank, two register banks of n_chan x dwi.
  - Write port: write enable, bank, index.
  - Registered read port on a selected bank.
  - Reused by other chain readers.

Test Plan (n_chan=4, dwi=28):
- Single frame: strobe, then gate 4 cycles with words 10,-20,30,-40.
  - frame_valid one cycle after -40; frame_count=1.
  - rd_addr 0..3 returns 10,-20,30,-40 at 1-cycle latency; rd_addr 5 returns 0.
- Back-to-back frames: gate held high 8 cycles, strobe on the 4th word.
  - Two frame_valid pulses, 4 cycles apart; no errors; second frame readable.
- Short burst: gate 3 words (1,2,3), then low.
  - err_short=1, no frame_valid; previous frame still readable unchanged.
- Long burst: gate 6 words, no strobe.
  - Publish after word 4; err_long=1; words 5-6 ignored.
  - err_clear then clears err_long.
- Mid-frame strobe: strobe on word 2 of a burst.
  - err_short set; the following 4 words publish correctly.
- Reset mid-capture after 2 words: outputs 0, no errors; the next full frame publishes with frame_count=1.

Source files
------------

// File: rtl/deser_bank.sv
// Two register banks of n_chan words each, used as a double buffer by chain
// readers: one bank is written while the other is read.
//
// Ports:
//   clk      single clock
//   rst      synchronous active-high reset (clears rd_data only; bank contents are kept)
//   we       write enable for wr_bank[wr_idx]
//   wr_bank  bank to write
//   wr_idx   word index to write (ignored when >= n_chan)
//   wr_data  word to write
//   rd_bank  bank to read
//   rd_addr  word index to read; indices >= n_chan read as zero
//   rd_data  registered read data, one-cycle latency
module deser_bank #(
  parameter int dwi    = 28,
  parameter int n_chan = 8,
  parameter int aw     = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic           wr_bank,
  input  logic [aw-1:0]  wr_idx,
  input  logic [dwi-1:0] wr_data,
  input  logic           rd_bank,
  input  logic [aw-1:0]  rd_addr,
  output logic [dwi-1:0] rd_data
);

  // Storage is sized to the full address space so any aw-bit index is a legal
  // array select; entries at or above n_chan are never written nor read.
  logic [dwi-1:0] mem_r [2][2**aw];
  logic [dwi-1:0] rd_data_r;

  // Bank write port; out-of-range indices are dropped.
  always_ff @(posedge clk) begin
    if (we && (int'(wr_idx) < n_chan)) begin
      mem_r[wr_bank][wr_idx] <= wr_data;
    end
  end

  // Registered read port; out-of-range addresses return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= {dwi{1'b0}};
    end else if (int'(rd_addr) < n_chan) begin
      rd_data_r <= mem_r[rd_bank][rd_addr];
    end else begin
      rd_data_r <= {dwi{1'b0}};
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/stream_deserialize.sv
// Receive end of the gated serial sample chain. Each gated burst following a
// snapshot strobe is rebuilt into an n_chan-word frame in the capture bank;
// a complete frame is published atomically by swapping banks. Short and long
// bursts raise sticky error flags and are never published.
//
// Ports:
//   clk          single clock
//   rst          synchronous active-high reset
//   stream_in    signed word from the end of the chain
//   gate_in      stream_in carries a valid word
//   strobe_in    chain snapshot strobe; next gated word is word 0 of a new frame
//   frame_valid  one-cycle pulse when a new frame is published
//   frame_count  number of published frames, wraps modulo 2**16
//   rd_addr      word index into the published frame
//   rd_data      published word, one-cycle latency
//   err_short    sticky: burst ended or restarted before n_chan words
//   err_long     sticky: gated words arrived after a complete frame
//   err_clear    clears both sticky flags (a simultaneous set wins)
module stream_deserialize #(
  parameter int dwi    = 28,
  parameter int n_chan = 8,
  parameter int aw     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic signed [dwi-1:0] stream_in,
  input  logic                  gate_in,
  input  logic                  strobe_in,
  output logic                  frame_valid,
  output logic [15:0]           frame_count,
  input  logic [aw-1:0]         rd_addr,
  output logic [dwi-1:0]        rd_data,
  output logic                  err_short,
  output logic                  err_long,
  input  logic                  err_clear
);

  localparam int cw = $clog2(n_chan + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  localparam logic [cw-1:0] CNT_LAST = cw'(n_chan - 1);

  logic [1:0]    state_r;
  logic [1:0]    state_n_s;
  logic [cw-1:0] cnt_r;
  logic [cw-1:0] cnt_n_s;
  logic          bank_sel_r;
  logic          frame_valid_r;
  logic [15:0]   frame_count_r;
  logic          err_short_r;
  logic          err_long_r;

  logic          we_s;
  logic          complete_s;
  logic          set_short_s;
  logic          set_long_s;

  // Next-state logic: the current word is handled first, then a strobe forces
  // a restart so a continuously high gate can carry back-to-back frames.
  always_comb begin
    state_n_s   = state_r;
    cnt_n_s     = cnt_r;
    we_s        = 1'b0;
    complete_s  = 1'b0;
    set_short_s = 1'b0;
    set_long_s  = 1'b0;

    case (state_r)
      IDLE: begin
        if (gate_in) begin
          we_s      = 1'b1;
          cnt_n_s   = cw'(1);
          state_n_s = CAPTURE;
        end else begin
          state_n_s = IDLE;
        end
      end
      CAPTURE: begin
        if (gate_in) begin
          we_s    = 1'b1;
          cnt_n_s = cnt_r + cw'(1);
          if (cnt_r == CNT_LAST) begin
            complete_s = 1'b1;
            state_n_s  = DONE;
          end else begin
            state_n_s = CAPTURE;
          end
        end else begin
          set_short_s = 1'b1;
          cnt_n_s     = {cw{1'b0}};
          state_n_s   = IDLE;
        end
      end
      DONE: begin
        // A word arriving with the strobe closes the old burst and is not an overrun.
        if (gate_in) begin
          set_long_s = ~strobe_in;
          state_n_s  = DONE;
        end else begin
          cnt_n_s   = {cw{1'b0}};
          state_n_s = IDLE;
        end
      end
      default: begin
        cnt_n_s   = {cw{1'b0}};
        state_n_s = IDLE;
      end
    endcase

    // A strobe in CAPTURE that does not land on the completing word truncates the frame.
    if (strobe_in) begin
      cnt_n_s     = {cw{1'b0}};
      state_n_s   = IDLE;
      set_short_s = set_short_s | ((state_r == CAPTURE) & ~complete_s);
    end else begin
      set_short_s = set_short_s;
    end
  end

  // FSM, word counter, bank swap and frame publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= {cw{1'b0}};
      bank_sel_r    <= 1'b0;
      frame_valid_r <= 1'b0;
      frame_count_r <= 16'd0;
    end else begin
      state_r       <= state_n_s;
      cnt_r         <= cnt_n_s;
      bank_sel_r    <= bank_sel_r ^ complete_s;
      frame_valid_r <= complete_s;
      frame_count_r <= frame_count_r + {15'd0, complete_s};
    end
  end

  // Sticky error flags; a set in the same cycle as err_clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_short_r <= 1'b0;
      err_long_r  <= 1'b0;
    end else begin
      err_short_r <= set_short_s | (err_short_r & ~err_clear);
      err_long_r  <= set_long_s  | (err_long_r  & ~err_clear);
    end
  end

  // The capture bank is the one not selected for reading, so a partial frame
  // can never become visible.
  deser_bank #(
    .dwi    (dwi),
    .n_chan (n_chan),
    .aw     (aw)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .we      (we_s & ~rst),
    .wr_bank (~bank_sel_r),
    .wr_idx  (aw'(cnt_r)),
    .wr_data (stream_in),
    .rd_bank (bank_sel_r),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign frame_valid = frame_valid_r;
  assign frame_count = frame_count_r;
  assign err_short   = err_short_r;
  assign err_long    = err_long_r;

endmodule
